// File: rtl/pending_write_scoreboard.sv
// Tracks in-flight register writes to stall or bypass dependent instructions at issue.
// Optional feature: define SCOREBOARD_STALL_CNT_EN to add a saturating 16-bit stall_count output.
module pending_write_scoreboard #(
    parameter int DEPTH   = 4,
    parameter int LD_LAT  = 3,
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    input  logic [5:0] issue_dest,
    input  logic       issue_is_load,
    input  logic [5:0] src_a,
    input  logic [5:0] src_b,
    input  logic       src_a_used,
    input  logic       src_b_used,
    output logic       stall,
    output logic       fwd_a,
    output logic       fwd_b,
    output logic [3:0] occupancy
`ifdef SCOREBOARD_STALL_CNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [5:0]       dest_q [DEPTH];
    logic [5:0]       dest_d [DEPTH];
    logic [3:0]       rem_q  [DEPTH];
    logic [3:0]       rem_d  [DEPTH];
    logic [3:0]       occupancy_q, occupancy_d;

    logic [DEPTH-1:0] busy;      // still in flight past this cycle
    logic [DEPTH-1:0] done;      // result forwardable this cycle, retires at the edge
    logic [DEPTH-1:0] hit_a, hit_b;
    logic [3:0]       busy_cnt;
    logic             full;
    logic             wait_a, wait_b, ready_a, ready_b;
    logic             accept, alloc;
    logic [IW-1:0]    alloc_idx;
    logic [3:0]       alloc_rem;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign busy[gi]  = valid_q[gi] && (rem_q[gi] > 4'd1);
            assign done[gi]  = valid_q[gi] && (rem_q[gi] == 4'd1);
            assign hit_a[gi] = valid_q[gi] && src_a_used && (src_a != 6'd0) && (dest_q[gi] == src_a);
            assign hit_b[gi] = valid_q[gi] && src_b_used && (src_b != 6'd0) && (dest_q[gi] == src_b);
        end
    endgenerate

    always_comb begin
        busy_cnt = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt = busy_cnt + {3'd0, busy[i]};
        end
    end

    assign full    = (busy_cnt == 4'(DEPTH));
    assign wait_a  = |(hit_a & busy);
    assign wait_b  = |(hit_b & busy);
    assign ready_a = |(hit_a & done);
    assign ready_b = |(hit_b & done);

    assign stall  = issue_valid && (full || wait_a || wait_b);
    assign fwd_a  = ready_a && !stall;
    assign fwd_b  = ready_b && !stall;
    assign accept = issue_valid && !stall;
    assign alloc  = accept && (issue_dest != 6'd0);

    assign alloc_rem = issue_is_load ? 4'(LD_LAT) : 4'(ALU_LAT);

    // Retiring entries count as free, so the lowest non-busy slot is always usable when not full.
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_idx = IW'(i);
            end
        end
    end

    always_comb begin
        valid_d     = busy;
        occupancy_d = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            dest_d[i] = dest_q[i];
            rem_d[i]  = valid_q[i] ? (rem_q[i] - 4'd1) : rem_q[i];
            // A newer write to the same tag supersedes the older one.
            if (alloc && busy[i] && (dest_q[i] == issue_dest)) begin
                valid_d[i] = 1'b0;
            end
            if (alloc && (alloc_idx == IW'(i))) begin
                valid_d[i] = 1'b1;
                dest_d[i]  = issue_dest;
                rem_d[i]   = alloc_rem;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_d = occupancy_d + {3'd0, valid_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= '0;
            occupancy_q <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= 6'd0;
                rem_q[i]  <= 4'd0;
            end
        end else begin
            valid_q     <= valid_d;
            occupancy_q <= occupancy_d;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= dest_d[i];
                rem_q[i]  <= rem_d[i];
            end
        end
    end

    assign occupancy = occupancy_q;

`ifdef SCOREBOARD_STALL_CNT_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_q <= 16'd0;
        end else if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_pending_write_scoreboard.sv
// Directed bench for pending_write_scoreboard: a short-load instance (LD_LAT=2) for
// hazard/bypass cases and a long-load instance (LD_LAT=5) for full and mid-flight reset.
module tb_pending_write_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    logic [5:0] issue_dest;
    logic       issue_is_load;
    logic [5:0] src_a, src_b;
    logic       src_a_used, src_b_used;

    logic       a_stall, a_fwd_a, a_fwd_b;
    logic [3:0] a_occ;
    logic       f_stall, f_fwd_a, f_fwd_b;
    logic [3:0] f_occ;
`ifdef SCOREBOARD_STALL_CNT_EN
    logic [15:0] a_scnt, f_scnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pending_write_scoreboard #(.DEPTH(4), .LD_LAT(2), .ALU_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_dest(issue_dest),
        .issue_is_load(issue_is_load), .src_a(src_a), .src_b(src_b),
        .src_a_used(src_a_used), .src_b_used(src_b_used),
        .stall(a_stall), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
`ifdef SCOREBOARD_STALL_CNT_EN
        .stall_count(a_scnt),
`endif
        .occupancy(a_occ)
    );

    pending_write_scoreboard #(.DEPTH(4), .LD_LAT(5), .ALU_LAT(1)) u_f (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_dest(issue_dest),
        .issue_is_load(issue_is_load), .src_a(src_a), .src_b(src_b),
        .src_a_used(src_a_used), .src_b_used(src_b_used),
        .stall(f_stall), .fwd_a(f_fwd_a), .fwd_b(f_fwd_b),
`ifdef SCOREBOARD_STALL_CNT_EN
        .stall_count(f_scnt),
`endif
        .occupancy(f_occ)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one instruction and let combinational outputs settle.
    task automatic drive(input logic v, input logic [5:0] d, input logic ld,
                         input logic [5:0] sa, input logic sau,
                         input logic [5:0] sb, input logic sbu);
        issue_valid   = v;
        issue_dest    = d;
        issue_is_load = ld;
        src_a         = sa;
        src_a_used    = sau;
        src_b         = sb;
        src_b_used    = sbu;
        #1;
        $display("txn t=%0t v=%0d dest=%0d ld=%0d a=%0d/%0d b=%0d/%0d | A stall=%0d fa=%0d fb=%0d occ=%0d | F stall=%0d occ=%0d",
                 $time, v, d, ld, sa, sau, sb, sbu, a_stall, a_fwd_a, a_fwd_b, a_occ, f_stall, f_occ);
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        check_eq("rst_occ_a", 32'(a_occ), 32'd0);
        check_eq("rst_occ_f", 32'(f_occ), 32'd0);
        check_eq("rst_stall", 32'(a_stall), 32'd0);
        check_eq("rst_fwd", 32'({a_fwd_a, a_fwd_b}), 32'd0);
        rst_n = 1'b1;

        // Load-use: load r5, dependent stalls one cycle then bypasses.
        drive(1'b1, 6'd5, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0);
        check_eq("lu_issue_stall", 32'(a_stall), 32'd0);
        tick();
        check_eq("lu_occ1", 32'(a_occ), 32'd1);
        drive(1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 6'd0, 1'b0);
        check_eq("lu_stall", 32'(a_stall), 32'd1);
        check_eq("lu_nofwd", 32'(a_fwd_a), 32'd0);
        tick();
        check_eq("lu_occ1b", 32'(a_occ), 32'd1);
        check_eq("lu_fwd_a", 32'(a_fwd_a), 32'd1);
        check_eq("lu_accept", 32'(a_stall), 32'd0);
        tick();
        check_eq("lu_occ0", 32'(a_occ), 32'd0);

        // ALU back-to-back: immediate bypass on src_b.
        drive(1'b1, 6'd7, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        check_eq("alu_occ1", 32'(a_occ), 32'd1);
        drive(1'b1, 6'd0, 1'b0, 6'd3, 1'b1, 6'd7, 1'b1);
        check_eq("alu_stall", 32'(a_stall), 32'd0);
        check_eq("alu_fwd_b", 32'(a_fwd_b), 32'd1);
        check_eq("alu_fwd_a", 32'(a_fwd_a), 32'd0);
        tick();
        check_eq("alu_occ0", 32'(a_occ), 32'd0);

        // WAW: ALU r9 replaces in-flight load r9.
        drive(1'b1, 6'd9, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        check_eq("waw_occ1", 32'(a_occ), 32'd1);
        drive(1'b1, 6'd9, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        check_eq("waw_nostall", 32'(a_stall), 32'd0);
        tick();
        check_eq("waw_occ_stays1", 32'(a_occ), 32'd1);
        drive(1'b1, 6'd0, 1'b0, 6'd9, 1'b1, 6'd0, 1'b0);
        check_eq("waw_stall", 32'(a_stall), 32'd0);
        check_eq("waw_fwd_a", 32'(a_fwd_a), 32'd1);
        tick();
        check_eq("waw_occ0", 32'(a_occ), 32'd0);

        // Register 0: never allocates, never matches.
        drive(1'b1, 6'd12, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        check_eq("r0_occ1", 32'(a_occ), 32'd1);
        drive(1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 6'd0, 1'b1);
        check_eq("r0_nostall", 32'(a_stall), 32'd0);
        check_eq("r0_nofwd", 32'({a_fwd_a, a_fwd_b}), 32'd0);
        tick();
        check_eq("r0_occ_unch", 32'(a_occ), 32'd1);
        idle();
        tick();
        check_eq("r0_occ0", 32'(a_occ), 32'd0);

        // Clear both instances before the full test.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Full: four long loads, fifth stalls until oldest reaches rem==1.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 6'(i), 1'b1, 6'd0, 1'b0, 6'd0, 1'b0);
            check_eq($sformatf("full_fill_stall%0d", i), 32'(f_stall), 32'd0);
            tick();
            check_eq($sformatf("full_fill_occ%0d", i), 32'(f_occ), 32'(i));
        end
        drive(1'b1, 6'd6, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0);
        check_eq("full_stall", 32'(f_stall), 32'd1);
        tick();
        check_eq("full_occ4", 32'(f_occ), 32'd4);
        check_eq("full_accept", 32'(f_stall), 32'd0);
        tick();
        check_eq("full_occ_after", 32'(f_occ), 32'd4);
`ifdef SCOREBOARD_STALL_CNT_EN
        check_eq("scnt_one", 32'(f_scnt), 32'd1);
`endif
        idle();
        tick();
        check_eq("mid_occ3", 32'(f_occ), 32'd3);

        // Reset mid-flight with an issue presented.
        rst_n = 1'b0;
        drive(1'b1, 6'd8, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        check_eq("mrst_occ0", 32'(f_occ), 32'd0);
        check_eq("mrst_stall", 32'(f_stall), 32'd0);
        check_eq("mrst_fwd", 32'({f_fwd_a, f_fwd_b}), 32'd0);
`ifdef SCOREBOARD_STALL_CNT_EN
        check_eq("mrst_scnt", 32'(f_scnt), 32'd0);
`endif
        rst_n = 1'b1;
        idle();
        tick();
        check_eq("post_occ0", 32'(f_occ), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
